// File: rtl/ffd_univ_reg.sv
// ffd_univ_reg: WIDTH-bit universal register (hold/load/shl/shr) with sync reset, set, enable and serial chaining.
// Define ROTATE_EN to add the ROT input, which turns shifts into rotates.
module ffd_univ_reg #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             C,
    input  logic             R,
    input  logic             S,
    input  logic             EN,
    input  logic [1:0]       M,
    input  logic [WIDTH-1:0] A,
    input  logic             SIL,
    input  logic             SIR,
`ifdef ROTATE_EN
    input  logic             ROT,
`endif
    output logic [WIDTH-1:0] Y,
    output logic             SO
);
    logic [WIDTH-1:0] y_q, y_d;
    logic             so_q, so_d;
    logic             rot;
    logic             shl_in, shr_in;
`ifdef ROTATE_EN
    assign rot = ROT;
`else
    assign rot = 1'b0;
`endif
    // A rotate feeds the bit leaving one end back into the other end.
    assign shl_in = rot ? y_q[WIDTH-1] : SIL;
    assign shr_in = rot ? y_q[0] : SIR;
    always_comb begin
        y_d  = S ? '1 :
               !EN ? y_q :
               M == 2'b01 ? A :
               M == 2'b10 ? {y_q[WIDTH-2:0], shl_in} :
               M == 2'b11 ? {shr_in, y_q[WIDTH-1:1]} : y_q;
        so_d = (S || !EN) ? so_q :
               M == 2'b10 ? y_q[WIDTH-1] :
               M == 2'b11 ? y_q[0] : so_q;
    end
    always_ff @(posedge C) begin
        if (R) begin
            y_q  <= RESET_VAL;
            so_q <= 1'b0;
        end else begin
            y_q  <= y_d;
            so_q <= so_d;
        end
    end
    assign Y  = y_q;
    assign SO = so_q;
endmodule

// File: tb/tb_ffd_univ_reg.sv
// tb_ffd_univ_reg: scoreboard bench for ffd_univ_reg; directed test-plan sequences then random stimulus.
module tb_ffd_univ_reg;
    localparam int W = 4;
    localparam logic [W-1:0] RV = 4'b0101;
    localparam int MASK = (1 << W) - 1;

    logic         C = 1'b0;
    logic         R = 1'b0, S = 1'b0, EN = 1'b0, SIL = 1'b0, SIR = 1'b0, ROT = 1'b0;
    logic [1:0]   M = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] Y;
    logic         SO;

    int n_checks = 0;
    int n_fail = 0;
    int my = 0;
    int mso = 0;
    int exp_q[$];

    always #5 C = ~C;

    ffd_univ_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .C(C), .R(R), .S(S), .EN(EN), .M(M), .A(A), .SIL(SIL), .SIR(SIR),
`ifdef ROTATE_EN
        .ROT(ROT),
`endif
        .Y(Y), .SO(SO)
    );

    // Reference model: register value as an integer, shifts as multiply/divide by two.
    task automatic drive(input bit r, input bit s, input bit en, input int m, input int a,
                         input bit sil, input bit sir, input bit rot_in);
        int b;
        bit rt;
        @(negedge C);
`ifdef ROTATE_EN
        rt = rot_in;
`else
        rt = 1'b0;
`endif
        R = r; S = s; EN = en; M = 2'(m); A = W'(a); SIL = sil; SIR = sir; ROT = rot_in;
        if (r) begin
            my = int'(RV);
            mso = 0;
        end else if (s) begin
            my = MASK;
        end else if (en) begin
            if (m == 1) my = a & MASK;
            else if (m == 2) begin
                b = (my >> (W - 1)) & 1;
                my = ((my * 2) + (rt ? b : int'(sil))) & MASK;
                mso = b;
            end else if (m == 3) begin
                b = my & 1;
                my = (my / 2) + ((rt ? b : int'(sir)) << (W - 1));
                mso = b;
            end
        end
        exp_q.push_back((my << 1) | mso);
    endtask

    initial begin : monitor
        int e;
        forever begin
            @(posedge C);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (Y !== W'(e >> 1)) begin
                    n_fail++;
                    $display("FAIL Y check %0d: got %b expected %b", n_checks, Y, W'(e >> 1));
                end
                n_checks++;
                if (SO !== 1'(e & 1)) begin
                    n_fail++;
                    $display("FAIL SO check %0d: got %b expected %b", n_checks, SO, 1'(e & 1));
                end
            end
        end
    end

    initial begin : stim
        drive(1, 1, 1, 1, 'hF, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 'hC, 0, 0, 0);
        repeat (2) drive(0, 0, 1, 0, 'h3, 1, 1, 0);
        repeat (4) drive(0, 0, 1, 2, 0, 1, 1, 0);
        drive(0, 0, 1, 1, 'h3, 0, 0, 0);
        repeat (2) drive(0, 0, 1, 3, 0, 1, 0, 0);
        drive(1, 1, 1, 3, 0, 1, 0, 0);
`ifdef ROTATE_EN
        drive(0, 0, 1, 1, 'h8, 0, 0, 1);
        repeat (4) drive(0, 0, 1, 2, 0, 0, 0, 1);
        repeat (4) drive(0, 0, 1, 3, 0, 0, 0, 1);
`endif
        // Reset seldom so long shift runs reach the wrap boundary.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 30) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 4) != 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, MASK)),
                  1'($urandom), 1'($urandom), 1'($urandom));
        repeat (3) @(negedge C);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ffd_univ_reg.md
Name: ffd_univ_reg

Overview:
Parametrised successor of the 4-bit D flip-flop register with set and reset. It is a WIDTH-bit universal register with synchronous reset, synchronous set, clock enable and four modes: hold, parallel load, shift left and shift right. It also provides serial in/out ports so several instances can be chained. It is used as the general storage and shift element in the lab datapath exercises.

Parameters:
WIDTH, 4, register width in bits (>=2)
RESET_VAL, 0, value loaded into Q on reset (WIDTH bits, zero-extended/truncated to WIDTH)

Ports:
C  input  1  clock; all state changes on the rising edge
R  input  1  synchronous active-high reset
S  input  1  synchronous active-high set (Q <= all ones)
EN  input  1  clock enable for mode operations
M  input  2  mode: 00 hold, 01 load, 10 shift left, 11 shift right
A  input  WIDTH  parallel load data
SIL  input  1  serial input entering bit 0 on shift left
SIR  input  1  serial input entering bit WIDTH-1 on shift right
Y  output  WIDTH  register contents
SO  output  1  serial out: bit shifted out on the last shift (registered)

Behaviour:
- All outputs are registers updated only on the rising edge of C; there is no asynchronous path.
- Priority on each edge: R > S > EN/mode.
- R=1: Y <= RESET_VAL, SO <= 0. This happens regardless of S, EN, M.
- R=0, S=1: Y <= {WIDTH{1'b1}}; SO holds.
- R=0, S=0, EN=0: Y and SO hold for any M.
- R=0, S=0, EN=1, M=00 (hold): Y and SO hold.
- M=01 (load): Y <= A; SO holds. Latency is one edge: A is visible on Y after the edge.
- M=10 (shift left): Y <= {Y[WIDTH-2:0], SIL}; SO <= old Y[WIDTH-1].
- M=11 (shift right): Y <= {SIR, Y[WIDTH-1:1]}; SO <= old Y[0].
- Inputs may be X before the first reset; Y is undefined until the first edge with R=1. The bench must reset first.
- Reset asserted in the middle of a shift sequence takes effect on the next edge; the partially shifted value is discarded.
- R and S asserted together: reset wins.
- After WIDTH consecutive shifts, Y is made up entirely of serial-in bits. This is the wrap boundary used for chaining.
- X on M while EN=1 is not allowed; the model may produce X.

Optional Feature:
ROTATE_EN
- Defined: adds input port ROT (1 bit) after SIR.
  - With ROT=1 during shift left, Y <= {Y[WIDTH-2:0], Y[WIDTH-1]} and SIL is ignored.
  - With ROT=1 during shift right, Y <= {Y[0], Y[WIDTH-1:1]} and SIR is ignored.
  - SO is updated as in a normal shift.
  - ROT has no effect in hold or load modes.
- Not defined: port ROT does not exist and shifts always take SIL/SIR.

Test Plan:
- WIDTH=4, RESET_VAL=4'b0101: R=1 for 1 edge with S=1, M=01, A=1111 -> Y=0101, SO=0.
- R=0, S=1 for 1 edge -> Y=1111. Then S=0, EN=0, M=01, A=0000 for 3 edges -> Y stays 1111.
- EN=1, M=01, A=1100 -> Y=1100 after 1 edge. Then M=00 for 2 edges -> Y=1100.
- From Y=1100, M=10, SIL=1 for 4 edges -> Y = 1001, 0011, 0111, 1111, with SO = 1, 1, 0, 0.
- From Y=0011, M=11, SIR=0 for 2 edges -> Y = 0001, 0000, with SO = 1, 1. Assert R=1 on the third edge mid-sequence -> Y=0101.
- With ROTATE_EN defined: Y=1000, M=10, ROT=1, SIL=0 for 4 edges -> Y = 0001, 0010, 0100, 1000 (returns to start).
